mem_be: RTL and testbench

MEM_BE -- requirements
Module: mem_be

---
 rtl/mem_be.sv | 122 ++++++++++++
 tb/tb_mem_be.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_be.sv
// Byte-enabled single-port memory with registered read, read-first collision
// behaviour, out-of-range error pulse and a sequential zeroing pass after reset or clr.
module mem_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     Data_in,
  output logic [DATA_W-1:0]     Data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  state
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0]   LAST      = IW'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  state_t          fsm, fsm_nxt;
  logic [IW-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic            acc_en;
  logic            in_range;
  logic            do_wr;
  logic            do_rd;
  logic            err_nxt;
  logic [IW-1:0]   idx;

  // Handshake: wr/rd are single-cycle requests sampled on the rising edge while
  // busy is low; a read answers one cycle later with rd_valid high for one cycle.
  always_comb begin
    acc_en   = (fsm == IDLE) && !clr;
    in_range = ({1'b0, addr} < DEPTH_EXT);
    idx      = addr[IW-1:0];
    do_wr    = acc_en && wr && in_range;
    do_rd    = acc_en && rd;
    err_nxt  = acc_en && (wr || rd) && !in_range;
  end

  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    case (fsm)
      INIT: begin
        if (cnt == LAST) begin
          fsm_nxt = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + IW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          fsm_nxt = INIT;
          cnt_nxt = '0;
        end
      end
      default: begin
        fsm_nxt = INIT;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= INIT;
      cnt <= '0;
    end else begin
      fsm <= fsm_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      err      <= err_nxt;
      if (do_rd) begin
        Data_out <= in_range ? mem[idx] : '0;
      end
    end
  end

  // The array has no reset; while rst is held the FSM sits in INIT at word 0,
  // so the only writes are zeroing writes that the INIT pass repeats anyway.
  always_ff @(posedge clk) begin
    if (fsm == INIT) begin
      mem[cnt] <= '0;
    end else if (do_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= Data_in[8*i +: 8];
        end
      end
    end
  end

  assign busy  = (fsm == INIT);
  assign state = fsm;

endmodule

// File: tb/tb_mem_be.sv
// Randomised scoreboard bench for mem_be: a word-array reference model predicts
// every cycle's rd_valid/err/busy and read data; a monitor pops and compares.
module tb_mem_be;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              wr  = 1'b0;
  logic              rd  = 1'b0;
  logic [NB-1:0]     be  = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] Data_in = '0;
  logic [DATA_W-1:0] Data_out;
  logic              rd_valid;
  logic              busy;
  logic              err;
  logic              state;

  mem_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .be(be),
    .addr(addr), .Data_in(Data_in), .Data_out(Data_out),
    .rd_valid(rd_valid), .busy(busy), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic vld;
    logic err;
    logic busy;
  } flg_t;

  logic [DATA_W-1:0] model [DEPTH];
  int                init_left = 0;
  logic [DATA_W-1:0] exp_q[$];
  flg_t              flags_q[$];
  logic [DATA_W-1:0] last_exp = '0;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Drive one cycle at a negedge, predict the outcome of the next rising edge.
  task automatic step(input logic c, input logic w, input logic r,
                      input logic [NB-1:0] b, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    flg_t f;
    logic [DATA_W-1:0] mask;
    clr = c; wr = w; rd = r; be = b; addr = a; Data_in = d;
    f = '0;
    if (init_left > 0) begin
      init_left--;
    end else if (c) begin
      zero_model();
      init_left = DEPTH;
    end else begin
      if (r) begin
        if (a < DEPTH) exp_q.push_back(model[int'(a)]);
        else           exp_q.push_back('0);
        f.vld = 1'b1;
      end
      if ((w || r) && a >= DEPTH) f.err = 1'b1;
      if (w && a < DEPTH) begin
        mask = '0;
        for (int i = 0; i < NB; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
        model[int'(a)] = (model[int'(a)] & ~mask) | (d & mask);
      end
    end
    f.busy = (init_left > 0);
    flags_q.push_back(f);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0, ADDR_W'(i), '0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return ADDR_W'(DEPTH + $urandom_range(0, 15));
      1:       return ADDR_W'(32'h0001_0000 | $urandom_range(0, 15));
      2:       return ADDR_W'($urandom);
      default: return ADDR_W'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic rand_step(input int clr_odds);
    step(($urandom_range(0, clr_odds) == 0), $urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1, NB'($urandom), rand_addr(), $urandom);
  endtask

  // Called at a negedge once the previous cycle has been checked.
  task automatic do_reset();
    rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0;
    #1;
    chk("rst_data_out", Data_out, '0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_state", state, 1'b0);
    repeat (3) @(negedge clk);
    last_exp  = '0;
    zero_model();
    init_left = DEPTH;
    rst = 1'b1;
  endtask

  initial begin : monitor
    flg_t f;
    forever begin
      @(posedge clk);
      #1;
      if (flags_q.size() > 0) begin
        f = flags_q.pop_front();
        chk("rd_valid", rd_valid, f.vld);
        chk("err", err, f.err);
        chk("busy", busy, f.busy);
        chk("state", state, !f.busy);
        if (f.vld) begin
          last_exp = exp_q.pop_front();
          chk("data_out", Data_out, last_exp);
        end else begin
          chk("data_out_hold", Data_out, last_exp);
        end
      end
    end
  end

  initial begin : driver
    @(negedge clk);
    do_reset();
    // Zeroing pass with requests that must all be ignored.
    for (int i = 0; i < DEPTH; i++) rand_step(3);
    read_all();

    step(1'b0, 1'b1, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'd0, 32'h0);
    idle(2);

    step(1'b0, 1'b1, 1'b0, 4'b0101, 32'd4, 32'hCAFE_BABE);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'd4, 32'h0);

    step(1'b0, 1'b1, 1'b0, 4'hF, 32'd4, 32'h1111_1111);
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'd4, 32'h2222_2222);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'd4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'd5, 32'h5555_5555);

    step(1'b0, 1'b1, 1'b0, 4'hF, 32'd16, 32'hBAD0_BAD0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'd20, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'hF, 32'h0001_0003, 32'hAAAA_AAAA);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0);
    step(1'b1, 1'b1, 1'b1, 4'hF, 32'd6, 32'h6666_6666);
    idle(DEPTH);
    read_all();

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'hF, ADDR_W'(i), $urandom);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(5);
    do_reset();
    for (int i = 0; i < DEPTH; i++) rand_step(3);
    read_all();

    for (int i = 0; i < 300; i++) rand_step(40);
    do_reset();
    for (int i = 0; i < 300; i++) rand_step(40);
    idle(DEPTH + 1);
    read_all();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
